// File: rtl/key_step_pulse.sv
// key_step_pulse: synchronise and debounce two active-low keys, then emit single-cycle inc/dec steps with hold auto-repeat
module key_step_pulse #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic button2,
  input  logic button3,
  output logic inc_pulse,
  output logic dec_pulse
);
  localparam int MAXP = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                        ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD) :
                        ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam int CW = $clog2(MAXP) + 1;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] deb_q, deb_d;
  logic [1:0][CW-1:0] dcnt_q, dcnt_d;
  logic [1:0] pressed_q, pressed_d;
  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic [CW-1:0] rcnt_q, rcnt_d, limit;
  logic inc_q, inc_d, dec_q, dec_d;
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == deb_q[i]) dcnt_d[i] = '0;
      else if (dcnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d[i]  = ~deb_q[i];
        dcnt_d[i] = '0;
      end else dcnt_d[i] = dcnt_q[i] + 1'b1;
    end
  end
  assign pressed_q = ~deb_q;
  assign pressed_d = ~deb_d;
  assign limit = (state_q == DELAY) ? CW'(REPEAT_DELAY - 1) : CW'(REPEAT_PERIOD - 1);
  // owner release is taken from the level being registered this edge, so no pulse lands on the release edge
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rcnt_d  = rcnt_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed_q == 2'b11) state_d = LOCK;
        else if (|pressed_q) begin
          owner_d = pressed_q[1];
          inc_d   = pressed_q[0];
          dec_d   = pressed_q[1];
          rcnt_d  = '0;
          state_d = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (!pressed_d[owner_q]) state_d = IDLE;
        else if (pressed_q[!owner_q]) state_d = LOCK;
        else if (rcnt_q == limit) begin
          inc_d   = ~owner_q;
          dec_d   = owner_q;
          rcnt_d  = '0;
          state_d = REPEAT;
        end else rcnt_d = rcnt_q + 1'b1;
      end
      default: state_d = (pressed_q == 2'b00) ? IDLE : LOCK;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      deb_q   <= 2'b11;
      dcnt_q  <= '0;
      state_q <= IDLE;
      owner_q <= 1'b0;
      rcnt_q  <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      sync1_q <= {button3, button2};
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      state_q <= state_d;
      owner_q <= owner_d;
      rcnt_q  <= rcnt_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end
  end
  assign inc_pulse = inc_q;
  assign dec_pulse = dec_q;
endmodule

// File: tb/tb_key_step_pulse.sv
// tb_key_step_pulse: directed scenarios plus randomized key activity against a behavioural reference
module tb_key_step_pulse;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic button2 = 1'b1;
  logic button3 = 1'b1;
  logic inc_pulse, dec_pulse;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  key_step_pulse #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clock(clk), .reset(reset), .button2(button2), .button3(button3),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse)
  );
  always #5 clk = ~clk;
  // reference: a key's level is accepted once its last D synchronised samples all disagree with it;
  // steps are timed from the previous step's edge number
  bit h2[$], h3[$];
  bit deb2 = 1'b1, deb3 = 1'b1, n2, n3, exp_inc = 1'b0, exp_dec = 1'b0, mown = 1'b0, ei, ed;
  int mode = 0;
  int last = 0;
  function automatic bit flips(input bit h[$], input bit d);
    for (int j = 2; j < D + 2; j++) if (h[j] == d) return 1'b0;
    return 1'b1;
  endfunction
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      h2 = {};
      h3 = {};
      for (int j = 0; j < D + 2; j++) begin h2.push_back(1'b1); h3.push_back(1'b1); end
      deb2 = 1'b1; deb3 = 1'b1; mode = 0; mown = 1'b0; exp_inc = 1'b0; exp_dec = 1'b0;
    end else begin
      h2.push_front(button2); void'(h2.pop_back());
      h3.push_front(button3); void'(h3.pop_back());
      n2 = flips(h2, deb2) ? !deb2 : deb2;
      n3 = flips(h3, deb3) ? !deb3 : deb3;
      ei = 1'b0; ed = 1'b0;
      if (mode == 0) begin
        if (!deb2 && !deb3) mode = 3;
        else if (!deb2 || !deb3) begin
          mown = !deb3; ei = !deb2; ed = !deb3; mode = 1; last = cyc;
        end
      end else if (mode == 3) begin
        if (deb2 && deb3) mode = 0;
      end else begin
        if (mown ? n3 : n2) mode = 0;
        else if (mown ? !deb2 : !deb3) mode = 3;
        else if (cyc - last == ((mode == 1) ? RD : RP)) begin
          ei = !mown; ed = mown; mode = 2; last = cyc;
        end
      end
      deb2 = n2; deb3 = n3; exp_inc = ei; exp_dec = ed;
    end
  end
  logic [2:0] st[$];
  int oi[$], od[$], mi[$], md[$];
  task automatic add(input logic [2:0] v, input int n);
    repeat (n) st.push_back(v);
  endtask
  task automatic run();
    oi = {}; od = {}; mi = {}; md = {};
    foreach (st[i]) begin
      {reset, button3, button2} = st[i];
      @(negedge clk);
      if (inc_pulse) oi.push_back(cyc);
      if (dec_pulse) od.push_back(cyc);
      if (exp_inc) mi.push_back(cyc);
      if (exp_dec) md.push_back(cyc);
    end
    st = {};
  endtask
  task automatic test_reset();
    reset = 1'b1; button2 = 1'b0; button3 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({inc_pulse, dec_pulse} !== 2'b00) begin
        errors++; $display("FAIL reset_outputs: got %b%b want 00", inc_pulse, dec_pulse);
      end
    end
    reset = 1'b0; button2 = 1'b1; button3 = 1'b1;
    repeat (8) begin
      @(negedge clk);
      checks++;
      if ({inc_pulse, dec_pulse} !== 2'b00) begin
        errors++; $display("FAIL idle_outputs: got %b%b want 00", inc_pulse, dec_pulse);
      end
    end
  endtask
  task automatic test_short_press();
    int base = cyc + 1;
    add(3'b010, 10); add(3'b011, 12); run();
    checks++;
    if (oi.size() !== 1) begin errors++; $display("FAIL short_inc_count: got %0d want 1", oi.size()); end
    checks++;
    if ((oi.size() > 0 ? oi[0] - base : -1) !== D + 2) begin
      errors++; $display("FAIL short_inc_time: got %0d want %0d", oi.size() > 0 ? oi[0] - base : -1, D + 2);
    end
    checks++;
    if (od.size() !== 0) begin errors++; $display("FAIL short_dec_count: got %0d want 0", od.size()); end
  endtask
  task automatic test_glitch();
    add(3'b001, 3); add(3'b011, 3); add(3'b001, 3); add(3'b011, 12); run();
    checks++;
    if (oi.size() !== 0) begin errors++; $display("FAIL glitch_inc_count: got %0d want 0", oi.size()); end
    checks++;
    if (od.size() !== 0) begin errors++; $display("FAIL glitch_dec_count: got %0d want 0", od.size()); end
  endtask
  task automatic test_long_hold();
    int base = cyc + 1;
    int want[$];
    want = '{6, 26, 34, 42, 50, 58};
    add(3'b010, 60); add(3'b011, 12); run();
    checks++;
    if (oi.size() !== want.size()) begin
      errors++; $display("FAIL hold_inc_count: got %0d want %0d", oi.size(), want.size());
    end
    for (int k = 0; k < want.size() && k < oi.size(); k++) begin
      checks++;
      if (oi[k] - base !== want[k]) begin
        errors++; $display("FAIL hold_inc_time[%0d]: got %0d want %0d", k, oi[k] - base, want[k]);
      end
    end
    checks++;
    if (od.size() !== 0) begin errors++; $display("FAIL hold_dec_count: got %0d want 0", od.size()); end
  endtask
  task automatic test_simultaneous();
    int base = cyc + 1;
    add(3'b000, 40); add(3'b011, 12); add(3'b001, 10); add(3'b011, 12); run();
    checks++;
    if (oi.size() !== 0) begin errors++; $display("FAIL simul_inc_count: got %0d want 0", oi.size()); end
    checks++;
    if (od.size() !== 1) begin errors++; $display("FAIL simul_dec_count: got %0d want 1", od.size()); end
    checks++;
    if ((od.size() > 0 ? od[0] - base : -1) !== 52 + D + 2) begin
      errors++; $display("FAIL simul_dec_time: got %0d want %0d", od.size() > 0 ? od[0] - base : -1, 52 + D + 2);
    end
  endtask
  task automatic test_conflict();
    int base = cyc + 1;
    add(3'b010, 16); add(3'b000, 34); add(3'b011, 12); run();
    checks++;
    if (oi.size() !== 1) begin errors++; $display("FAIL conflict_inc_count: got %0d want 1", oi.size()); end
    checks++;
    if ((oi.size() > 0 ? oi[0] - base : -1) !== D + 2) begin
      errors++; $display("FAIL conflict_inc_time: got %0d want %0d", oi.size() > 0 ? oi[0] - base : -1, D + 2);
    end
    checks++;
    if (od.size() !== 0) begin errors++; $display("FAIL conflict_dec_count: got %0d want 0", od.size()); end
  endtask
  task automatic test_reset_mid_repeat();
    int base = cyc + 1;
    int want[$];
    want = '{6, 26, 38, 58, 66, 74, 82};
    add(3'b010, 30); add(3'b110, 2); add(3'b010, 48); add(3'b011, 12); run();
    checks++;
    if (oi.size() !== want.size()) begin
      errors++; $display("FAIL rst_inc_count: got %0d want %0d", oi.size(), want.size());
    end
    for (int k = 0; k < want.size() && k < oi.size(); k++) begin
      checks++;
      if (oi[k] - base !== want[k]) begin
        errors++; $display("FAIL rst_inc_time[%0d]: got %0d want %0d", k, oi[k] - base, want[k]);
      end
    end
    checks++;
    if (od.size() !== 0) begin errors++; $display("FAIL rst_dec_count: got %0d want 0", od.size()); end
  endtask
  task automatic test_random();
    logic [2:0] pat[4];
    int both = 0;
    pat = '{3'b010, 3'b001, 3'b000, 3'b011};
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 11) == 0) add({1'b1, 2'($urandom_range(0, 3))}, $urandom_range(1, 3));
      else add(pat[$urandom_range(0, 3)], $urandom_range(1, 30));
    end
    add(3'b011, 15); run();
    checks++;
    if (oi.size() !== mi.size()) begin errors++; $display("FAIL rand_inc_count: got %0d want %0d", oi.size(), mi.size()); end
    for (int k = 0; k < oi.size() && k < mi.size(); k++) begin
      checks++;
      if (oi[k] !== mi[k]) begin errors++; $display("FAIL rand_inc_edge[%0d]: got %0d want %0d", k, oi[k], mi[k]); end
    end
    checks++;
    if (od.size() !== md.size()) begin errors++; $display("FAIL rand_dec_count: got %0d want %0d", od.size(), md.size()); end
    for (int k = 0; k < od.size() && k < md.size(); k++) begin
      checks++;
      if (od[k] !== md[k]) begin errors++; $display("FAIL rand_dec_edge[%0d]: got %0d want %0d", k, od[k], md[k]); end
    end
    foreach (oi[a]) foreach (od[b]) if (oi[a] == od[b]) both++;
    checks++;
    if (both !== 0) begin errors++; $display("FAIL rand_exclusive: got %0d coincident pulses want 0", both); end
  endtask
  initial begin
    test_reset();
    test_short_press();
    test_glitch();
    test_long_hold();
    test_simultaneous();
    test_conflict();
    test_reset_mid_repeat();
    for (int r = 0; r < 4; r++) test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_step_pulse.md
# key_step_pulse

Conditions the two active-low threshold keys (KEY2 increment, KEY3 decrement) into clean single-cycle step pulses for the threshold selector. Per key: two-flop synchroniser, then a counter-based debouncer. A shared hold state machine emits one pulse per press, then auto-repeats while the key is held. It sits directly upstream of the threshold selector, which adds or subtracts one step per pulse.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronised cycles required to accept a level change (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000: cycles from the first pulse to the first auto-repeat pulse (500 ms).
- REPEAT_PERIOD, 5000000: cycles between auto-repeat pulses (100 ms).
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- button2  in  1  raw KEY2, active-low (0 = pressed), asynchronous to clock.
- button3  in  1  raw KEY3, active-low (0 = pressed), asynchronous to clock.
- inc_pulse  out  1  one-cycle, registered increment step.
- dec_pulse  out  1  one-cycle, registered decrement step.

## Operation
- Synchroniser: two flops per key.
  - Reset value is 1 (released).
- Debouncer: per key, a debounced level plus a stability counter.
  - Counter width is $clog2 of the largest parameter plus 1.
  - While the synchronised level equals the debounced level, the counter holds 0.
  - While they differ, the counter increments each cycle.
  - On the cycle the counter would reach DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Any return to the debounced level before that clears the counter, so a glitch shorter than DEBOUNCE_CYCLES is ignored.
  - Reset: debounced level = released, counter = 0.
- Hold FSM states: IDLE, DELAY, REPEAT, LOCK. It also holds an owner bit (INC/DEC) and a repeat counter.
  - IDLE, exactly one key debounced-pressed: pulse that key's output, record it as owner, clear the counter, go to DELAY.
  - IDLE, both keys become pressed on the same cycle: no pulse, go to LOCK.
  - DELAY: the counter increments. When it reaches REPEAT_DELAY-1, pulse the owner, clear the counter, go to REPEAT.
  - REPEAT: the counter increments. When it reaches REPEAT_PERIOD-1, pulse the owner and clear the counter. Stay in REPEAT.
  - DELAY or REPEAT, owner debounced-released: go to IDLE, no pulse. Release wins over a same-cycle counter expiry.
  - DELAY or REPEAT, non-owner debounced-pressed while the owner is still held: go to LOCK, no pulse. This wins over a same-cycle expiry.
  - LOCK: no pulses. Go to IDLE only when both keys are debounced-released.
- Pulse exclusivity:
  - inc_pulse and dec_pulse are never high in the same cycle.
  - Each is high for exactly one cycle per emitted step.
- Reset:
  - Outputs = 0, FSM = IDLE, owner = INC, repeat counter = 0.
  - Reset asserted mid-hold aborts all state immediately; no pulse in the cycle after reset is sampled.
  - A key held through reset release is re-debounced from scratch and yields exactly one fresh first pulse.

## Timing
- Edge e0 is the first rising edge sampling a key low, with the key then held steady.
- The debounced level flips at edge e0+DEBOUNCE_CYCLES+1.
- The first pulse is registered at edge e0+DEBOUNCE_CYCLES+2 and is high for that one cycle.
- First auto-repeat pulse: exactly REPEAT_DELAY cycles after the first pulse.
- Later repeats: every REPEAT_PERIOD cycles.
- A release sampled at edge r0 makes the debounced level go released at r0+DEBOUNCE_CYCLES+1.
  - Pulses due before that edge are still emitted.
  - None are emitted from that edge onward.
- Key held through reset release: no pulse earlier than DEBOUNCE_CYCLES+2 cycles after reset deasserts.
- Output latency from the FSM decision to the pulse is one registered stage. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Short press: hold button2 low for 10 cycles, then release -> exactly one inc_pulse, 6 edges after the first low sample; dec_pulse stays 0.
- Glitch: button3 low for 3 cycles, high for 3, low for 3 -> no pulses at all.
- Long hold: button2 low for 60 cycles -> inc_pulse at the first pulse cycle t, then t+20, t+28, t+36, t+44, t+52 (6 pulses). No pulses after the debounced release.
- Simultaneous: both keys fall on the same cycle and are held for 40 cycles -> no pulses. Then release both, press button3 alone -> one dec_pulse after 6 edges.
- Conflict mid-hold: button2 held, button3 pressed 10 cycles after the first inc_pulse -> no further pulses on either output until both are released.
- Reset mid-repeat: reset high for 2 cycles during REPEAT with button2 still held -> outputs 0 during reset. Exactly one inc_pulse no earlier than 6 cycles after reset deasserts, then repeats resume at +20, +8.
